// File: rtl/bombman_pkg.sv
// bombman_pkg: shared cell/game-state codes, LFSR constants and arena helpers for the BombMan init path.
package bombman_pkg;
  localparam logic [1:0] CELL_BLANK = 2'd0;
  localparam logic [1:0] CELL_BLOCK = 2'd1;
  localparam logic [1:0] CELL_PA    = 2'd2;
  localparam logic [1:0] CELL_PB    = 2'd3;
  localparam logic [1:0] GS_READY   = 2'd0;
  localparam logic [1:0] GS_INIT    = 2'd3;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  localparam int LFSR_TAP0 = 15;
  localparam int LFSR_TAP1 = 13;
  localparam int LFSR_TAP2 = 12;
  localparam int LFSR_TAP3 = 10;
  typedef enum logic [1:0] {ST_IDLE, ST_SEED, ST_SWEEP, ST_FINISH} state_e;
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[LFSR_TAP0] ^ l[LFSR_TAP1] ^ l[LFSR_TAP2] ^ l[LFSR_TAP3]};
  endfunction
  function automatic logic adj(input logic [3:0] r, c, sr, sc);
    return (r == sr && (c == sc + 4'd1 || c == sc - 4'd1)) ||
           (c == sc && (r == sr + 4'd1 || r == sr - 4'd1));
  endfunction
  // rl/cl are the last row/column; player B spawns diagonally inside that corner
  function automatic logic [1:0] classify(input logic [3:0] r, c, rl, cl, input logic mode,
                                          input logic [3:0] rnd, input logic [4:0] density);
    logic [3:0] br, bc;
    br = rl - 4'd1;
    bc = cl - 4'd1;
    return (r == 4'd1 && c == 4'd1) ? CELL_PA :
           (r == br && c == bc) ? CELL_PB :
           (r == 4'd0 || c == 4'd0 || r == rl || c == cl) ? CELL_BLOCK :
           (adj(r, c, 4'd1, 4'd1) || adj(r, c, br, bc)) ? CELL_BLANK :
           !mode ? ((!r[0] && !c[0]) ? CELL_BLOCK : CELL_BLANK) :
           ({1'b0, rnd} < density) ? CELL_BLOCK : CELL_BLANK;
  endfunction
endpackage

// File: rtl/arena_init_seq_if.sv
// arena_init_seq_if: start/done handshake from the game controller plus the cell-write bus to the RAMs.
interface arena_init_seq_if #(parameter int HEALTH_W = 2);
  logic                start;
  logic                mode;
  logic [15:0]         seed;
  logic                busy;
  logic                done;
  logic                wr_en;
  logic [3:0]          wr_row;
  logic [3:0]          wr_col;
  logic [1:0]          wr_cell;
  logic [1:0]          wr_bomb;
  logic [HEALTH_W-1:0] healthA;
  logic [HEALTH_W-1:0] healthB;
  logic [1:0]          game_state;
  modport master (output start, mode, seed,
                  input busy, done, wr_en, wr_row, wr_col, wr_cell, wr_bomb, healthA, healthB, game_state);
  modport slave (input start, mode, seed,
                 output busy, done, wr_en, wr_row, wr_col, wr_cell, wr_bomb, healthA, healthB, game_state);
endinterface

// File: rtl/arena_lfsr16.sv
// arena_lfsr16: 16-bit Fibonacci LFSR; rnd_o is the low nibble of the value the register takes next.
module arena_lfsr16
  import bombman_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [15:0] seed_i,
  output logic [3:0]  rnd_o
);
  logic [15:0] lfsr_q, lfsr_d, seed_eff;
  always_comb begin
    seed_eff = (seed_i == 16'd0) ? LFSR_DEFAULT_SEED : seed_i;
    lfsr_d   = lfsr_step(lfsr_q);
    rnd_o    = load_i ? seed_eff[3:0] : lfsr_d[3:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= LFSR_DEFAULT_SEED;
    else if (load_i) lfsr_q <= seed_eff;
    else if (en_i) lfsr_q <= lfsr_d;
endmodule

// File: rtl/arena_init_seq.sv
// arena_init_seq: on start, sweeps every arena cell once (row-major, one per clock) emitting
// border/spawn/block writes, then loads health and returns the game to ready.
module arena_init_seq
  import bombman_pkg::*;
#(
  parameter int ROWS       = 10,
  parameter int COLS       = 10,
  parameter int HEALTH_W   = 2,
  parameter int MAX_HEALTH = 3,
  parameter int DENSITY    = 4
) (
  input logic             clk,
  input logic             rst_n,
  arena_init_seq_if.slave bus
);
  localparam logic [3:0] RL = 4'(ROWS - 1);
  localparam logic [3:0] CL = 4'(COLS - 1);
  localparam logic [4:0] DENS = 5'(DENSITY);
  localparam logic [HEALTH_W-1:0] HMAX = HEALTH_W'(MAX_HEALTH);
  state_e              state_q;
  logic                mode_q;
  logic [15:0]         seed_q;
  logic [3:0]          row_q, col_q, row_d, col_d, rnd;
  logic [1:0]          cell_d;
  logic                last_d;
  logic                busy_q, done_q, wr_en_q;
  logic [3:0]          wr_row_q, wr_col_q;
  logic [1:0]          wr_cell_q, gs_q;
  logic [HEALTH_W-1:0] ha_q, hb_q;
  arena_lfsr16 u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (state_q == ST_SEED),
    .en_i   (state_q == ST_SWEEP),
    .seed_i (seed_q),
    .rnd_o  (rnd)
  );
  // row_q/col_q address the cell being classified, one ahead of the registered write
  always_comb begin
    cell_d = classify(row_q, col_q, RL, CL, mode_q, rnd, DENS);
    last_d = wr_row_q == RL && wr_col_q == CL;
    col_d  = (col_q == CL) ? 4'd0 : col_q + 4'd1;
    row_d  = (col_q != CL) ? row_q : (row_q == RL) ? 4'd0 : row_q + 4'd1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      seed_q    <= 16'd0;
      row_q     <= 4'd0;
      col_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_row_q  <= 4'd0;
      wr_col_q  <= 4'd0;
      wr_cell_q <= CELL_BLANK;
      gs_q      <= GS_READY;
      ha_q      <= '0;
      hb_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start) begin
          state_q <= ST_SEED;
          mode_q  <= bus.mode;
          seed_q  <= bus.seed;
          busy_q  <= 1'b1;
          gs_q    <= GS_INIT;
          row_q   <= 4'd0;
          col_q   <= 4'd0;
        end
        ST_SEED, ST_SWEEP: if (state_q == ST_SWEEP && last_d) begin
          state_q <= ST_FINISH;
          wr_en_q <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          ha_q    <= HMAX;
          hb_q    <= HMAX;
          gs_q    <= GS_READY;
        end else begin
          state_q   <= ST_SWEEP;
          wr_en_q   <= 1'b1;
          wr_row_q  <= row_q;
          wr_col_q  <= col_q;
          wr_cell_q <= cell_d;
          row_q     <= row_d;
          col_q     <= col_d;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_row     = wr_row_q;
  assign bus.wr_col     = wr_col_q;
  assign bus.wr_cell    = wr_cell_q;
  assign bus.wr_bomb    = CELL_BLANK;
  assign bus.healthA    = ha_q;
  assign bus.healthB    = hb_q;
  assign bus.game_state = gs_q;
endmodule

// File: tb/tb_arena_init_seq.sv
// tb_arena_init_seq: directed bench for three arena configurations (10x10 D4, 7x13 D4, 10x10 D0).
module tb_arena_init_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic st [3] = '{1'b0, 1'b0, 1'b0};
  logic mode = 1'b0;
  logic [15:0] seed = 16'd0;
  arena_init_seq_if #(.HEALTH_W(2)) if_a ();
  arena_init_seq_if #(.HEALTH_W(2)) if_b ();
  arena_init_seq_if #(.HEALTH_W(2)) if_c ();
  assign if_a.start = st[0];
  assign if_b.start = st[1];
  assign if_c.start = st[2];
  assign if_a.mode = mode;
  assign if_b.mode = mode;
  assign if_c.mode = mode;
  assign if_a.seed = seed;
  assign if_b.seed = seed;
  assign if_c.seed = seed;
  arena_init_seq #(.ROWS(10), .COLS(10), .HEALTH_W(2), .MAX_HEALTH(3), .DENSITY(4))
    u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  arena_init_seq #(.ROWS(7), .COLS(13), .HEALTH_W(2), .MAX_HEALTH(3), .DENSITY(4))
    u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  arena_init_seq #(.ROWS(10), .COLS(10), .HEALTH_W(2), .MAX_HEALTH(3), .DENSITY(0))
    u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));
  logic [20:0] obs [3];
  assign obs[0] = {if_a.busy, if_a.done, if_a.wr_en, if_a.wr_row, if_a.wr_col, if_a.wr_cell,
                   if_a.wr_bomb, if_a.healthA, if_a.healthB, if_a.game_state};
  assign obs[1] = {if_b.busy, if_b.done, if_b.wr_en, if_b.wr_row, if_b.wr_col, if_b.wr_cell,
                   if_b.wr_bomb, if_b.healthA, if_b.healthB, if_b.game_state};
  assign obs[2] = {if_c.busy, if_c.done, if_c.wr_en, if_c.wr_row, if_c.wr_col, if_c.wr_cell,
                   if_c.wr_bomb, if_c.healthA, if_c.healthB, if_c.game_state};
  int checks = 0, errors = 0;
  logic m_busy, m_done, m_en;
  logic [3:0] m_row, m_col;
  logic [1:0] m_cell, m_bomb, m_ha, m_hb, m_gs;
  int n_wr, done_cyc, n_done, order_err, bomb_err, busy_err;
  logic [1:0] cmap [16][16];
  logic [1:0] seq [$];
  logic [1:0] seq0 [$];
  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
  function automatic logic [1:0] ref_cell(input int r, c, rows, cols, input logic md,
                                          input logic [15:0] l, input int dens);
    int da, db;
    da = (r > 1 ? r - 1 : 1 - r) + (c > 1 ? c - 1 : 1 - c);
    db = (r > rows - 2 ? r - rows + 2 : rows - 2 - r) + (c > cols - 2 ? c - cols + 2 : cols - 2 - c);
    if (da == 0) return 2'd2;
    if (db == 0) return 2'd3;
    if (r == 0 || c == 0 || r == rows - 1 || c == cols - 1) return 2'd1;
    if (da == 1 || db == 1) return 2'd0;
    if (!md) return (r % 2 == 0 && c % 2 == 0) ? 2'd1 : 2'd0;
    return (int'(l[3:0]) < dens) ? 2'd1 : 2'd0;
  endfunction
  function automatic int gold_err(input int rows, cols, input logic md, input logic [15:0] sd, input int dens);
    logic [15:0] l;
    int e;
    e = 0;
    l = (sd == 16'd0) ? 16'hACE1 : sd;
    if (seq.size() != rows * cols) return -1;
    for (int k = 0; k < rows * cols; k++) begin
      if (seq[k] !== ref_cell(k / cols, k % cols, rows, cols, md, l, dens)) e++;
      l = lstep(l);
    end
    return e;
  endfunction
  task automatic run(input int s, rows, cols, input logic md, input logic [15:0] sd, input int p1, p2);
    n_wr = 0; done_cyc = -1; n_done = 0; order_err = 0; bomb_err = 0; busy_err = 0;
    seq.delete();
    @(negedge clk);
    mode = md; seed = sd; st[s] = 1'b1;
    for (int cyc = 1; cyc <= rows * cols + 8; cyc++) begin
      @(negedge clk);
      st[s] = (cyc == p1 || cyc == p2);
      {m_busy, m_done, m_en, m_row, m_col, m_cell, m_bomb, m_ha, m_hb, m_gs} = obs[s];
      if (m_en) begin
        if (m_row != 4'(n_wr / cols) || m_col != 4'(n_wr % cols)) order_err++;
        cmap[m_row][m_col] = m_cell;
        seq.push_back(m_cell);
        n_wr++;
      end
      if (m_bomb != 2'd0) bomb_err++;
      if (m_done) begin n_done++; done_cyc = cyc; end
      if (m_busy != (cyc <= rows * cols + 1)) busy_err++;
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (obs[s] !== 21'd0) begin errors++; $display("FAIL reset_state inst %0d got %h exp 0", s, obs[s]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_fixed_10x10();
    int tr[8] = '{1, 8, 2, 1, 2, 0, 4, 3};
    int tc[8] = '{1, 8, 2, 2, 1, 5, 4, 5};
    int te[8] = '{2, 3, 1, 0, 0, 1, 1, 0};
    run(0, 10, 10, 1'b0, 16'd0, -1, -1);
    checks++; if (n_wr !== 100) begin errors++; $display("FAIL fixed_writes got %0d exp 100", n_wr); end
    checks++; if (order_err !== 0) begin errors++; $display("FAIL fixed_order got %0d exp 0", order_err); end
    checks++; if (done_cyc !== 102) begin errors++; $display("FAIL fixed_done_cycle got %0d exp 102", done_cyc); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL fixed_done_count got %0d exp 1", n_done); end
    checks++; if (busy_err !== 0) begin errors++; $display("FAIL fixed_busy got %0d bad cycles exp 0", busy_err); end
    checks++; if (bomb_err !== 0) begin errors++; $display("FAIL fixed_bomb got %0d exp 0", bomb_err); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cmap[tr[i]][tc[i]] !== 2'(te[i])) begin
        errors++; $display("FAIL fixed_cell (%0d,%0d) got %0d exp %0d", tr[i], tc[i], cmap[tr[i]][tc[i]], te[i]);
      end
    end
    checks++; if (gold_err(10, 10, 1'b0, 16'd0, 4) !== 0) begin errors++; $display("FAIL fixed_map got mismatches exp 0"); end
    checks++;
    if (if_a.healthA !== 2'd3 || if_a.healthB !== 2'd3 || if_a.game_state !== 2'd0) begin
      errors++; $display("FAIL fixed_final got hA=%0d hB=%0d gs=%0d exp 3 3 0", if_a.healthA, if_a.healthB, if_a.game_state);
    end
  endtask
  task automatic test_random_seed();
    int d;
    run(0, 10, 10, 1'b1, 16'h0000, -1, -1);
    seq0 = seq;
    run(0, 10, 10, 1'b1, 16'hACE1, -1, -1);
    d = (seq0.size() == seq.size()) ? 0 : 1000;
    foreach (seq[k]) if (k < seq0.size() && seq0[k] !== seq[k]) d++;
    checks++; if (d !== 0 || seq.size() != 100) begin errors++; $display("FAIL seed0_vs_ace1 got %0d diffs exp 0", d); end
    checks++; if (gold_err(10, 10, 1'b1, 16'hACE1, 4) !== 0) begin errors++; $display("FAIL random_ace1_map got mismatches exp 0"); end
    run(0, 10, 10, 1'b1, 16'h1234, -1, -1);
    d = gold_err(10, 10, 1'b1, 16'h1234, 4);
    checks++; if (d !== 0) begin errors++; $display("FAIL random_1234_map got %0d exp 0", d); end
    checks++;
    if (cmap[1][2] !== 2'd0 || cmap[2][1] !== 2'd0 || cmap[8][7] !== 2'd0 || cmap[7][8] !== 2'd0) begin
      errors++; $display("FAIL random_spawn_clear got %0d%0d%0d%0d exp 0000", cmap[1][2], cmap[2][1], cmap[8][7], cmap[7][8]);
    end
    checks++; if (bomb_err !== 0) begin errors++; $display("FAIL random_bomb got %0d exp 0", bomb_err); end
  endtask
  task automatic test_density0();
    int nz;
    run(2, 10, 10, 1'b1, 16'hBEEF, -1, -1);
    nz = 0;
    for (int r = 1; r < 9; r++)
      for (int c = 1; c < 9; c++)
        if (!(r == 1 && c == 1) && !(r == 8 && c == 8) && cmap[r][c] !== 2'd0) nz++;
    checks++; if (nz !== 0 || n_wr !== 100) begin errors++; $display("FAIL density0_interior got %0d blocks %0d writes exp 0 100", nz, n_wr); end
    checks++; if (cmap[0][0] !== 2'd1 || cmap[9][4] !== 2'd1) begin errors++; $display("FAIL density0_border got %0d %0d exp 1 1", cmap[0][0], cmap[9][4]); end
  endtask
  task automatic test_reset_mid();
    int w, bad;
    w = 0;
    bad = 0;
    @(negedge clk);
    mode = 1'b0; seed = 16'd0; st[0] = 1'b1;
    for (int i = 0; i < 200 && w < 40; i++) begin
      @(negedge clk);
      st[0] = 1'b0;
      if (if_a.wr_en) w++;
    end
    checks++; if (w !== 40) begin errors++; $display("FAIL midreset_reach got %0d writes exp 40", w); end
    rst_n = 1'b0;
    #1;
    checks++; if (obs[0] !== 21'd0) begin errors++; $display("FAIL midreset_outputs got %h exp 0", obs[0]); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (obs[0] !== 21'd0) bad++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (if_a.done || if_a.wr_en) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL midreset_quiet got %0d bad cycles exp 0", bad); end
    run(0, 10, 10, 1'b0, 16'd0, -1, -1);
    checks++;
    if (n_wr !== 100 || order_err !== 0 || done_cyc !== 102) begin
      errors++; $display("FAIL midreset_resweep got %0d writes %0d order %0d done exp 100 0 102", n_wr, order_err, done_cyc);
    end
  endtask
  task automatic test_ignore_start();
    run(0, 10, 10, 1'b0, 16'd0, 5, 102);
    checks++; if (n_done !== 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", n_done); end
    checks++; if (done_cyc !== 102 || n_wr !== 100) begin errors++; $display("FAIL ignore_timing got done %0d writes %0d exp 102 100", done_cyc, n_wr); end
    checks++; if (busy_err !== 0) begin errors++; $display("FAIL ignore_busy got %0d bad cycles exp 0", busy_err); end
  endtask
  task automatic test_7x13();
    int b;
    run(1, 7, 13, 1'b0, 16'd0, -1, -1);
    checks++; if (n_wr !== 91 || order_err !== 0) begin errors++; $display("FAIL r7c13_writes got %0d order %0d exp 91 0", n_wr, order_err); end
    checks++; if (done_cyc !== 93) begin errors++; $display("FAIL r7c13_done got %0d exp 93", done_cyc); end
    checks++; if (cmap[5][11] !== 2'd3 || cmap[1][1] !== 2'd2) begin errors++; $display("FAIL r7c13_players got %0d %0d exp 3 2", cmap[5][11], cmap[1][1]); end
    b = 0;
    for (int c = 0; c < 13; c++) if (cmap[6][c] !== 2'd1) b++;
    for (int r = 0; r < 7; r++) if (cmap[r][12] !== 2'd1) b++;
    checks++; if (b !== 0) begin errors++; $display("FAIL r7c13_border got %0d non-block exp 0", b); end
    checks++;
    if (cmap[4][10] !== 2'd1 || cmap[4][11] !== 2'd0 || cmap[5][10] !== 2'd0) begin
      errors++; $display("FAIL r7c13_interior got %0d %0d %0d exp 1 0 0", cmap[4][10], cmap[4][11], cmap[5][10]);
    end
    run(1, 7, 13, 1'b1, 16'h5A5A, -1, -1);
    checks++; if (gold_err(7, 13, 1'b1, 16'h5A5A, 4) !== 0) begin errors++; $display("FAIL r7c13_random_map got mismatches exp 0"); end
    checks++;
    if (cmap[1][2] !== 2'd0 || cmap[2][1] !== 2'd0 || cmap[4][11] !== 2'd0 || cmap[5][10] !== 2'd0 || bomb_err !== 0) begin
      errors++; $display("FAIL r7c13_random_spawn got %0d%0d%0d%0d bomb %0d exp 0000 0", cmap[1][2], cmap[2][1], cmap[4][11], cmap[5][10], bomb_err);
    end
  endtask
  initial begin
    test_reset();
    test_fixed_10x10();
    test_random_seed();
    test_density0();
    test_reset_mid();
    test_ignore_start();
    test_7x13();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
